// File: rtl/fb_arbiter.sv
// Double-buffered frame buffer arbiter: display reads have strict priority over
// application reads/writes, which are steered to the back buffer.
module fb_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              app_req,
    input  logic              app_we,
    input  logic [ADDR_W-1:0] app_addr,
    input  logic [DATA_W-1:0] app_wdata,
    output logic              app_ack,
    output logic              app_rvalid,
    output logic [DATA_W-1:0] app_rdata,
    input  logic              frame_start,
    input  logic              swap_req,
    output logic              front_buf,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       collisions,
    output logic [1:0]        access_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DISP_RD = 2'd1;
    localparam logic [1:0] APP_WR  = 2'd2;
    localparam logic [1:0] APP_RD  = 2'd3;

    // Handshakes: disp_req is a single-cycle strobe with no backpressure.
    // app_req is a level held with stable we/addr/wdata until app_ack; a request
    // seen while app_ack=1 is the tail of the acknowledged one and is ignored.
    // disp_valid / app_rvalid are one-cycle strobes, three cycles after request.

    logic [1:0] state;
    logic [1:0] state_next;
    logic [1:0] rd_tag;
    logic       swap_pending;
    logic       app_wins;
    logic       app_lost;

    assign access_state = state;
    assign app_wins     = app_req && !app_ack;
    assign app_lost     = disp_req && app_wins;

    always_comb begin
        state_next = IDLE;
        if (disp_req) begin
            state_next = DISP_RD;
        end else if (app_wins) begin
            state_next = app_we ? APP_WR : APP_RD;
        end
    end

    // Memory command register: the op for a request sampled in cycle N is
    // presented to the memory during N+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            app_ack   <= 1'b0;
        end else begin
            state   <= state_next;
            mem_en  <= (state_next != IDLE);
            mem_we  <= (state_next == APP_WR);
            app_ack <= (state_next == APP_WR) || (state_next == APP_RD);
            case (state_next)
                DISP_RD: mem_addr <= {front_buf, disp_addr};
                APP_RD:  mem_addr <= {~front_buf, app_addr};
                APP_WR: begin
                    mem_addr  <= {~front_buf, app_addr};
                    mem_wdata <= app_wdata;
                end
                default: begin
                    mem_addr  <= mem_addr;
                    mem_wdata <= mem_wdata;
                end
            endcase
        end
    end

    // rd_tag names the owner of the data arriving on mem_rdata this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_tag     <= IDLE;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            app_rvalid <= 1'b0;
            app_rdata  <= '0;
        end else begin
            rd_tag     <= ((state == DISP_RD) || (state == APP_RD)) ? state : IDLE;
            disp_valid <= (rd_tag == DISP_RD);
            app_rvalid <= (rd_tag == APP_RD);
            if (rd_tag == DISP_RD) begin
                disp_data <= mem_rdata;
            end
            if (rd_tag == APP_RD) begin
                app_rdata <= mem_rdata;
            end
        end
    end

    // Swaps are deferred to vertical blanking; a same-cycle request counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            front_buf    <= 1'b0;
            swap_pending <= 1'b0;
        end else if (frame_start && (swap_pending || swap_req)) begin
            front_buf    <= ~front_buf;
            swap_pending <= 1'b0;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            collisions <= '0;
        end else if (app_lost && (collisions != 16'hFFFF)) begin
            collisions <= collisions + 16'd1;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboarded bench for fb_arbiter: a buffer-level model predicts every memory
// op, read strobe, ack, front buffer and collision count; a monitor compares.
module tb_fb_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 24;
  localparam int MEM_N  = 1 << (ADDR_W + 1);

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } rd_item_t;

  typedef struct {
    int                due;
    logic              we;
    logic [ADDR_W:0]   addr;
    logic [DATA_W-1:0] wdata;
  } op_item_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              disp_req = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              app_req = 1'b0;
  logic              app_we = 1'b0;
  logic [ADDR_W-1:0] app_addr = '0;
  logic [DATA_W-1:0] app_wdata = '0;
  logic              app_ack;
  logic              app_rvalid;
  logic [DATA_W-1:0] app_rdata;
  logic              frame_start = 1'b0;
  logic              swap_req = 1'b0;
  logic              front_buf;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W:0]   mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       collisions;
  logic [1:0]        access_state;

  fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .app_req(app_req), .app_we(app_we), .app_addr(app_addr), .app_wdata(app_wdata),
    .app_ack(app_ack), .app_rvalid(app_rvalid), .app_rdata(app_rdata),
    .frame_start(frame_start), .swap_req(swap_req), .front_buf(front_buf),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .collisions(collisions), .access_state(access_state)
  );

  // synchronous-read memory attached to the DUT
  logic [DATA_W-1:0] phys_mem [0:MEM_N-1];
  logic [DATA_W-1:0] shadow   [0:MEM_N-1];
  always @(posedge clk) begin
    if (mem_en && mem_we) phys_mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= phys_mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  rd_item_t disp_q[$];
  rd_item_t app_q[$];
  op_item_t op_q[$];
  logic              fb_m = 1'b0, pend_m = 1'b0, ack_m = 1'b0;
  int                coll_m = 0;
  logic [DATA_W-1:0] last_disp = '0, last_app = '0;
  logic              mon_on = 1'b0;
  logic              drop_next = 1'b0;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: one call per clock, using the inputs driven for this cycle.
  task automatic tick();
    int       n;
    logic     fb_n, pend_n, ack_n, was_reset;
    int       coll_n;
    logic [ADDR_W:0] a;
    rd_item_t it;
    op_item_t op;
    n = cyc;
    fb_n = fb_m; pend_n = pend_m; ack_n = 1'b0; coll_n = coll_m;
    was_reset = reset;
    if (reset) begin
      while (disp_q.size() > 0 && disp_q[$].due > n) void'(disp_q.pop_back());
      while (app_q.size() > 0 && app_q[$].due > n) void'(app_q.pop_back());
      while (op_q.size() > 0 && op_q[$].due > n) void'(op_q.pop_back());
      fb_n = 1'b0; pend_n = 1'b0; coll_n = 0;
    end else begin
      if (disp_req) begin
        a = {fb_m, disp_addr};
        it.due = n + 3; it.data = shadow[a]; disp_q.push_back(it);
        op.due = n + 1; op.we = 1'b0; op.addr = a; op.wdata = '0; op_q.push_back(op);
        if (app_req && !ack_m && coll_n < 65535) coll_n++;
      end else if (app_req && !ack_m) begin
        a = {~fb_m, app_addr};
        ack_n = 1'b1;
        op.due = n + 1; op.we = app_we; op.addr = a; op.wdata = app_we ? app_wdata : '0;
        op_q.push_back(op);
        if (app_we) shadow[a] = app_wdata;
        else begin
          it.due = n + 3; it.data = shadow[a]; app_q.push_back(it);
        end
      end
      if (frame_start && (pend_m || swap_req)) begin
        fb_n = ~fb_m; pend_n = 1'b0;
      end else if (swap_req) pend_n = 1'b1;
    end
    @(posedge clk);
    #1;
    fb_m = fb_n; pend_m = pend_n; ack_m = ack_n; coll_m = coll_n;
    if (was_reset) begin
      last_disp = '0; last_app = '0;
    end
  endtask

  task automatic app_start(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    app_req = 1'b1; app_we = we; app_addr = addr; app_wdata = wd;
  endtask

  // Requester keeps app_req up through the ack cycle, then releases it.
  task automatic app_update();
    if (drop_next) begin
      app_req = 1'b0; drop_next = 1'b0;
    end else if (app_req && ack_m) drop_next = 1'b1;
  endtask

  // monitor
  always @(negedge clk) begin
    if (mon_on) begin
      chk("app_ack", app_ack, ack_m);
      chk("front_buf", front_buf, fb_m);
      chk("collisions", collisions, coll_m);
      if (disp_q.size() > 0 && disp_q[0].due == cyc) begin
        chk("disp_valid", disp_valid, 1);
        chk("disp_data", disp_data, disp_q[0].data);
        last_disp = disp_q[0].data;
        void'(disp_q.pop_front());
      end else begin
        chk("disp_valid_idle", disp_valid, 0);
        chk("disp_data_hold", disp_data, last_disp);
      end
      if (app_q.size() > 0 && app_q[0].due == cyc) begin
        chk("app_rvalid", app_rvalid, 1);
        chk("app_rdata", app_rdata, app_q[0].data);
        last_app = app_q[0].data;
        void'(app_q.pop_front());
      end else begin
        chk("app_rvalid_idle", app_rvalid, 0);
        chk("app_rdata_hold", app_rdata, last_app);
      end
      if (op_q.size() > 0 && op_q[0].due == cyc) begin
        chk("mem_en", mem_en, 1);
        chk("mem_we", mem_we, op_q[0].we);
        chk("mem_addr", mem_addr, op_q[0].addr);
        if (op_q[0].we) chk("mem_wdata", mem_wdata, op_q[0].wdata);
        void'(op_q.pop_front());
      end else begin
        chk("mem_en_idle", mem_en, 0);
      end
    end
  end

  initial begin
    for (int i = 0; i < MEM_N; i++) begin
      phys_mem[i] = 24'(i * 7919) ^ 24'h5A5A5A;
      shadow[i]   = phys_mem[i];
    end
    phys_mem[17'h00010] = 24'hFF0000; shadow[17'h00010] = 24'hFF0000;
    phys_mem[17'h10003] = 24'h0000FF; shadow[17'h10003] = 24'h0000FF;

    reset = 1'b1;
    tick();
    mon_on = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // display fetch from front buffer 0
    disp_req = 1'b1; disp_addr = 16'h0010;
    tick();
    disp_req = 1'b0;
    @(negedge clk);
    chk("t41_mem_en", mem_en, 1);
    chk("t41_mem_addr", mem_addr, 17'h00010);
    tick(); tick();
    @(negedge clk);
    chk("t41_disp_valid", disp_valid, 1);
    chk("t41_disp_data", disp_data, 24'hFF0000);
    tick();

    // app write lands in the back buffer, single ack
    app_start(1'b1, 16'h0005, 24'h00FF00);
    tick();
    @(negedge clk);
    chk("t42_app_ack", app_ack, 1);
    chk("t42_mem_we", mem_we, 1);
    chk("t42_mem_addr", mem_addr, 17'h10005);
    tick();
    app_req = 1'b0;
    @(negedge clk);
    chk("t42_single_ack", app_ack, 0);
    tick(); tick();

    // app read from the back buffer
    app_start(1'b0, 16'h0003, '0);
    tick();
    tick();
    app_req = 1'b0;
    tick();
    @(negedge clk);
    chk("t46_app_rvalid", app_rvalid, 1);
    chk("t46_app_rdata", app_rdata, 24'h0000FF);
    chk("t46_disp_valid", disp_valid, 0);
    repeat (3) tick();

    // display starves a held app request for four cycles
    reset = 1'b1; tick(); reset = 1'b0;
    app_start(1'b1, 16'h0007, 24'h123456);
    for (int i = 0; i < 4; i++) begin
      disp_req = 1'b1; disp_addr = 16'(i);
      tick();
    end
    disp_req = 1'b0;
    tick();
    @(negedge clk);
    chk("t43_app_ack", app_ack, 1);
    chk("t43_collisions", collisions, 4);
    tick();
    app_req = 1'b0;
    repeat (4) tick();

    // deferred swap, repeated requests give one toggle
    reset = 1'b1; tick(); reset = 1'b0;
    swap_req = 1'b1; tick(); tick(); swap_req = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("t44_front_before", front_buf, 0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    @(negedge clk);
    chk("t44_front_after", front_buf, 1);
    app_start(1'b1, 16'h0009, 24'hABCDEF);
    tick();
    @(negedge clk);
    chk("t44_app_buf0", mem_addr, 17'h00009);
    tick(); app_req = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    @(negedge clk);
    chk("t44_no_second_toggle", front_buf, 1);
    swap_req = 1'b1; frame_start = 1'b1; tick(); swap_req = 1'b0; frame_start = 1'b0;
    @(negedge clk);
    chk("t44_same_cycle_swap", front_buf, 0);
    repeat (3) tick();

    // reset while a display read is in flight
    disp_req = 1'b1; disp_addr = 16'h0010; tick(); disp_req = 1'b0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    chk("t45_disp_valid", disp_valid, 0);
    chk("t45_mem_en", mem_en, 0);
    chk("t45_mem_we", mem_we, 0);
    chk("t45_mem_addr", mem_addr, 0);
    chk("t45_mem_wdata", mem_wdata, 0);
    chk("t45_disp_data", disp_data, 0);
    chk("t45_app_rdata", app_rdata, 0);
    chk("t45_app_ack", app_ack, 0);
    repeat (4) tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      app_update();
      if (!app_req && !drop_next && $urandom_range(0, 1) == 1)
        app_start(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 24'($urandom));
      disp_req    = ($urandom_range(0, 2) == 0);
      disp_addr   = 16'($urandom_range(0, 15));
      swap_req    = ($urandom_range(0, 9) == 0);
      frame_start = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; disp_req = 1'b0; app_req = 1'b0; swap_req = 1'b0; frame_start = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk("drain_empty", disp_q.size() + app_q.size() + op_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
